// File: rtl/regfile_pkg.sv
// Shared types and defaults for the reg_file_bus register bank.
// The move FSM encoding is fixed at 2 bits so it can be probed from microcode debug.
package regfile_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefDepth = 4;

    localparam logic [1:0] StIdleEnc = 2'd0;
    localparam logic [1:0] StMvRdEnc = 2'd1;
    localparam logic [1:0] StMvWrEnc = 2'd2;

    typedef enum logic [1:0] {
        StIdle = StIdleEnc,
        StMvRd = StMvRdEnc,
        StMvWr = StMvWrEnc
    } state_e;

endpackage

// File: rtl/reg_file_bus_if.sv
// Control strobes from the microcode sequencer to the register bank, plus the busy flag back.
// The data bus itself stays a plain inout net on the register bank.
interface reg_file_bus_if #(
    parameter int unsigned WIDTH = regfile_pkg::DefWidth,
    parameter int unsigned DEPTH = regfile_pkg::DefDepth
) ();
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] im;
    logic [AW-1:0]    addr_a;
    logic [AW-1:0]    addr_b;
    logic             rs1;
    logic             rs2;
    logic             ws1;
    logic             mv;
    logic             busy;

    modport master (
        output im, addr_a, addr_b, rs1, rs2, ws1, mv,
        input  busy
    );

    modport slave (
        input  im, addr_a, addr_b, rs1, rs2, ws1, mv,
        output busy
    );

endinterface

// File: rtl/reg_cell.sv
// Single WIDTH-bit storage register with load enable and async active-low reset.
module reg_cell #(
    parameter int unsigned WIDTH = regfile_pkg::DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_bus.sv
// Bank of DEPTH registers on a shared tri-state bus with a two-cycle register move.
// Build option: define REGFILE_R0_ZERO_EN to hardwire R[0] to zero.
module reg_file_bus import regfile_pkg::*; #(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_bus_if.slave   ctl,
    inout  wire [WIDTH-1:0] bus
);

    state_e           state_q, state_d;
    logic [AW-1:0]    dst_q, dst_d, src_q, src_d;
    logic [WIDTH-1:0] temp_q, temp_d;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic             wr_req;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_a, rd_src;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
`ifdef REGFILE_R0_ZERO_EN
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_cell
            reg_cell #(.WIDTH(WIDTH)) u_cell (
                .clk (clk),
                .rst (rst),
                .en  (wr_en[i]),
                .d   (wr_data),
                .q   (regs[i])
            );
        end
`else
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (wr_en[i]),
            .d   (wr_data),
            .q   (regs[i])
        );
`endif
    end

    // Addresses beyond DEPTH never match, so they read 0 and write nothing.
    always_comb begin
        rd_a   = '0;
        rd_src = '0;
        wr_en  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ctl.addr_a == AW'(i)) rd_a = regs[i];
            if (src_q == AW'(i)) rd_src = regs[i];
            wr_en[i] = wr_req && (wr_addr == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dst_q   <= '0;
            src_q   <= '0;
            temp_q  <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            temp_q  <= temp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src_d   = src_q;
        temp_d  = temp_q;
        wr_req  = 1'b0;
        wr_addr = ctl.addr_a;
        wr_data = ctl.im;
        unique case (state_q)
            StIdle: begin
                if (ctl.rs1) begin
                    wr_req = 1'b1;
                end else if (ctl.rs2) begin
                    // Loading our own driven value would be a loopback; drop it, mv too.
                    wr_req  = !ctl.ws1;
                    wr_data = bus;
                end else if (ctl.mv) begin
                    dst_d   = ctl.addr_a;
                    src_d   = ctl.addr_b;
                    state_d = StMvRd;
                end
            end
            StMvRd: begin
                temp_d  = rd_src;
                state_d = StMvWr;
            end
            StMvWr: begin
                wr_req  = 1'b1;
                wr_addr = dst_q;
                wr_data = temp_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ctl.busy = (state_q != StIdle);
    assign bus      = (ctl.ws1 && state_q == StIdle) ? rd_a : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_file_bus.sv
// Self-checking bench for reg_file_bus: a 4x4 instance plus an 8x8 parametrised instance.
module tb_reg_file_bus;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_bus_if #(.WIDTH(4), .DEPTH(4)) ifa ();
    reg_file_bus_if #(.WIDTH(8), .DEPTH(8)) ifb ();

    wire  [3:0] bus4;
    wire  [7:0] bus8;
    logic [3:0] drv4;
    logic       en4;
    assign bus4 = en4 ? drv4 : 4'bzzzz;

    reg_file_bus #(.WIDTH(4), .DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .ctl (ifa),
        .bus (bus4)
    );

    reg_file_bus #(.WIDTH(8), .DEPTH(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .ctl (ifb),
        .bus (bus8)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

`ifdef REGFILE_R0_ZERO_EN
    localparam logic [3:0] R0AfterMove = 4'h0;
`else
    localparam logic [3:0] R0AfterMove = 4'hA;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.im = '0; ifa.addr_a = '0; ifa.addr_b = '0;
        ifa.rs1 = 0; ifa.rs2 = 0; ifa.ws1 = 0; ifa.mv = 0;
        ifb.im = '0; ifb.addr_a = '0; ifb.addr_b = '0;
        ifb.rs1 = 0; ifb.rs2 = 0; ifb.ws1 = 0; ifb.mv = 0;
        en4 = 0; drv4 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #10;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", ifa.busy);
        end
        rst = 1;
        tick();
        for (int a = 0; a < 4; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 4; a++) begin
            ifa.ws1 = 1; ifa.addr_a = 2'(a);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (bus4 !== exp[3:0]) begin
                errors++; $display("FAIL reset_read R%0d: got %h want %h", a, bus4, exp[3:0]);
            end
        end
        ifa.ws1 = 0;
    endtask

    task automatic test_imm_load();
        ifa.rs1 = 1; ifa.addr_a = 2; ifa.im = 4'b1001;
        exp_q.push_back(8'h09);
        tick();
        ifa.rs1 = 0;
        for (int a = 0; a < 4; a++) if (a != 2) exp_q.push_back(8'h00);
        ifa.ws1 = 1; ifa.addr_a = 2;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL imm_load R2: got %h want %h", bus4, exp[3:0]);
        end
        for (int a = 0; a < 4; a++) begin
            if (a == 2) continue;
            ifa.addr_a = 2'(a);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (bus4 !== exp[3:0]) begin
                errors++; $display("FAIL imm_other R%0d: got %h want %h", a, bus4, exp[3:0]);
            end
        end
        ifa.ws1 = 0;
    endtask

    task automatic test_bus_load();
        ifa.rs2 = 1; ifa.addr_a = 1; en4 = 1; drv4 = 4'b0110;
        exp_q.push_back(8'h06);
        tick();
        ifa.rs2 = 0; en4 = 0;
        ifa.ws1 = 1;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL bus_load R1: got %h want %h", bus4, exp[3:0]);
        end
        // Probe with 0: any leftover drive of R1 (nonzero) corrupts the readback.
        ifa.ws1 = 0; en4 = 1; drv4 = 4'h0;
        #1;
        checks++;
        if (bus4 !== 4'h0) begin
            errors++; $display("FAIL bus_release: got %h want released (probe 0)", bus4);
        end
        en4 = 0;
    endtask

    task automatic test_move();
        ifa.rs1 = 1; ifa.addr_a = 3; ifa.im = 4'hA;
        tick();
        ifa.rs1 = 0;
        ifa.mv = 1; ifa.addr_a = 0; ifa.addr_b = 3;
        exp_q.push_back({4'h0, R0AfterMove});
        exp_q.push_back(8'h06);
        #1;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL move_busy_pre: got %b want 0", ifa.busy);
        end
        tick();
        ifa.mv = 0;
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL move_busy_e1: got %b want 1", ifa.busy);
        end
        ifa.rs1 = 1; ifa.addr_a = 1; ifa.im = 4'hF;
        ifa.ws1 = 1; ifa.addr_b = 2;
        en4 = 1; drv4 = 4'h0;
        #1;
        checks++;
        if (bus4 !== 4'h0) begin
            errors++; $display("FAIL move_bus_z: got %h want released (probe 0)", bus4);
        end
        ifa.addr_a = 3;
        #1;
        checks++;
        if (bus4 !== 4'h0) begin
            errors++; $display("FAIL move_bus_z_r3: got %h want released (probe 0)", bus4);
        end
        ifa.addr_a = 1;
        tick();
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL move_busy_e2: got %b want 1", ifa.busy);
        end
        tick();
        ifa.rs1 = 0; ifa.ws1 = 0; en4 = 0;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL move_busy_e3: got %b want 0", ifa.busy);
        end
        ifa.ws1 = 1; ifa.addr_a = 0;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL move_dst R0: got %h want %h", bus4, exp[3:0]);
        end
        ifa.addr_a = 1;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL move_rs1_ignored R1: got %h want %h", bus4, exp[3:0]);
        end
        ifa.ws1 = 0;
    endtask

    task automatic test_priority();
        ifa.rs1 = 1; ifa.rs2 = 1; ifa.mv = 1; ifa.im = 4'h5;
        ifa.addr_a = 1; ifa.addr_b = 2; en4 = 1; drv4 = 4'hC;
        exp_q.push_back(8'h05);
        tick();
        ifa.rs1 = 0; ifa.rs2 = 0; ifa.mv = 0; en4 = 0;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL prio_no_move: got busy %b want 0", ifa.busy);
        end
        ifa.ws1 = 1;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL prio_rs1 R1: got %h want %h", bus4, exp[3:0]);
        end
        // ws1+rs2 on R2 while a foreign value also sits on the bus: R2 must keep 9.
        ifa.addr_a = 2; ifa.rs2 = 1; en4 = 1; drv4 = 4'h6;
        exp_q.push_back(8'h09);
        tick();
        ifa.rs2 = 0; en4 = 0;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL ws1_rs2 R2: got %h want %h", bus4, exp[3:0]);
        end
        ifa.ws1 = 0;
    endtask

    task automatic test_back_to_back();
        ifa.mv = 1; ifa.addr_a = 1; ifa.addr_b = 1;
        tick();
        ifa.mv = 0;
        tick();
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL self_move_busy: got %b want 1", ifa.busy);
        end
        tick();
        ifa.rs1 = 1; ifa.addr_a = 2; ifa.im = 4'h3;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h05);
        tick();
        ifa.rs1 = 0; ifa.ws1 = 1;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL b2b_load R2: got %h want %h", bus4, exp[3:0]);
        end
        ifa.addr_a = 1;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus4 !== exp[3:0]) begin
            errors++; $display("FAIL self_move R1: got %h want %h", bus4, exp[3:0]);
        end
        ifa.ws1 = 0;
    endtask

    task automatic test_reset_mid_move();
        ifa.mv = 1; ifa.addr_a = 1; ifa.addr_b = 2;
        tick();
        ifa.mv = 0;
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got busy %b want 1", ifa.busy);
        end
        #2 rst = 0;
        #1;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL midreset_busy: got %b want 0", ifa.busy);
        end
        @(negedge clk);
        rst = 1;
        tick();
        tick();
        tick();
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL midreset_resume: got busy %b want 0", ifa.busy);
        end
        for (int a = 0; a < 4; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 4; a++) begin
            ifa.ws1 = 1; ifa.addr_a = 2'(a);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (bus4 !== exp[3:0]) begin
                errors++; $display("FAIL midreset_read R%0d: got %h want %h", a, bus4, exp[3:0]);
            end
        end
        ifa.ws1 = 0;
    endtask

    task automatic test_param();
        ifb.rs1 = 1; ifb.addr_a = 7; ifb.im = 8'hC3;
        tick();
        ifb.rs1 = 0;
        ifb.mv = 1; ifb.addr_a = 5; ifb.addr_b = 7;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC3);
        tick();
        ifb.mv = 0; ifb.addr_a = 0; ifb.addr_b = 0;
        tick();
        tick();
        checks++;
        if (ifb.busy !== 1'b0) begin
            errors++; $display("FAIL param_busy: got %b want 0", ifb.busy);
        end
        ifb.ws1 = 1; ifb.addr_a = 5;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus8 !== exp) begin
            errors++; $display("FAIL param_move R5: got %h want %h", bus8, exp);
        end
        ifb.addr_a = 7;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (bus8 !== exp) begin
            errors++; $display("FAIL param_src R7: got %h want %h", bus8, exp);
        end
        ifb.ws1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_imm_load();
        test_bus_load();
        test_move();
        test_priority();
        test_back_to_back();
        test_reset_mid_move();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
